mspc_v_exec_seq: RTL and testbench
==================================

# mspc_v_exec_seq

Execute sequencer for the most-simple processor core: accepts one decoded ALU command at a time, reads operands from an internal 16×64 register file, and drives the combinational 64-bit ALU (`inpa`/`inpb`/`sel` in; `numoutp`/`booloutp` out). It captures the ALU result, writes it back, and returns it on a response handshake. It is the initiator/consumer side of the ALU port and sits between instruction decode and the ALU.

## Interface
- `DATA_W`, 64, operand/result width.
- `REG_N`, 16, register count; index width is `$clog2(REG_N)` (4).
- `SEL_W`, 4, ALU opcode width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  sequencer can accept.
- `cmd_sel`  in  4  ALU opcode.
- `cmd_rd`, `cmd_rs1`, `cmd_rs2`  in  4 each  destination and source indices.
- `cmd_imm_en`  in  1  use `cmd_imm` instead of `rs2` as operand B.
- `cmd_imm`  in  64  immediate.
- `alu_inpa`, `alu_inpb`  out  64  ALU operands (registered).
- `alu_sel`  out  4  ALU select (registered).
- `alu_numoutp`  in  64  ALU numeric result.
- `alu_booloutp`  in  1  ALU boolean result.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts.
- `rsp_result`  out  64  captured `numoutp`.
- `rsp_flag`  out  1  captured `booloutp`.
- `rsp_rd`  out  4  destination written.
- `flag_q`  out  1  architectural flag: the last committed `booloutp`.

## Operation
- FSM states: IDLE, READ, EXEC, RESP.
- IDLE: `cmd_ready`=1. On `cmd_valid && cmd_ready`, latch sel, rd, rs1, rs2, imm_en and imm, then go to READ.
- READ: load `alu_inpa`←R[rs1]; load `alu_inpb`←(imm_en ? imm : R[rs2]); load `alu_sel`←sel. Go to EXEC.
- EXEC: the ALU output is stable. On the exiting edge:
  - capture `alu_numoutp` into `rsp_result` and R[rd];
  - capture `alu_booloutp` into `rsp_flag` and `flag_q`;
  - set `rsp_rd`←rd.
  - Go to RESP.
- RESP: `rsp_valid`=1. Hold it and all `rsp_*` stable until `rsp_ready`, then go to IDLE.
- `cmd_ready` is high only in IDLE. There is no overlap, so no data hazards arise: the write in EXEC always precedes the next READ.
- R0 reads as 0. Writes to R0 are discarded from the register file, but `rsp_result` still reports the ALU value.
- All 16 `sel` codes pass through unmodified. The sequencer never interprets the opcode.
- `alu_*` outputs hold their last value outside READ/EXEC.
- Reset: state IDLE; all registers, including the register file, go to 0; `cmd_ready`=1 after release; every other output is 0.
- Reset mid-operation: the in-flight command is dropped with no write-back and no response.
- `rsp_ready` asserted outside RESP is ignored. `cmd_*` inputs outside an accept cycle are ignored.

## Timing
- Accept at edge T. Registered operands are valid after T+1. Write-back and capture happen at T+2. `rsp_valid` is high from T+2 until the handshake.
- Minimum command-to-command period: 4 cycles, with `rsp_ready` held high. Each cycle `rsp_ready` is low adds one cycle.
- `alu_numoutp`/`alu_booloutp` are sampled only at the EXEC edge, which gives the combinational ALU one full cycle.
- No combinational path exists from any input to any output except `cmd_ready`, which is decoded from state only.

## Structure
- Package `mspc_v_pkg`: `DATA_W`/`REG_N`/`SEL_W` constants, FSM state enum, command struct (sel, rd, rs1, rs2, imm_en, imm).
- Sub-module `mspc_v_regfile`: 2 async-read ports, 1 sync-write port, async active-low clear, R0 hardwired to zero. The FSM lives in `mspc_v_exec_seq`.

## Test plan
The bench ALU model treats sel 0000 as ADD with bool = carry, and sel 0001 as bool = (a == b) with num = 0.
- **Reset and idle:** hold `rst_n` low 3 cycles → all outputs 0, `cmd_ready`=1 after release, and any register read via ADD R0+R0 yields 0.
- **Immediate add:** ADD rd=1, rs1=0, imm_en=1, imm=0x5 with `rsp_ready`=1 → `alu_inpa`=0 and `alu_inpb`=5 at T+1; `rsp_valid` at T+2 with `rsp_result`=5, `rsp_rd`=1; next command accepted at T+4.
- **Back-to-back dependency and carry:** ADD R2=R1+imm 0xFFFF_FFFF_FFFF_FFFB → result 0, `rsp_flag`=1, `flag_q`=1. Then compare sel 0001 of R2 with R0 → `rsp_flag`=1.
- **Backpressure:** hold `rsp_ready` low 5 cycles → `rsp_valid`, `rsp_result` and `rsp_rd` stable, `cmd_ready`=0, and a `cmd_valid` pulse is not accepted. The response completes 1 cycle after `rsp_ready` rises.
- **R0 write:** ADD rd=0, imm=7 → `rsp_result`=7; a following read of R0 returns 0.
- **Reset mid-op:** assert `rst_n` during EXEC of a write of 9 to R3 → no `rsp_valid`, and R3 reads 0 afterwards.

Source files
------------

// File: rtl/mspc_v_pkg.sv
// Shared constants, FSM state encoding and command record for the
// most-simple processor core execute sequencer.
package mspc_v_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned REG_N  = 16;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned IDX_W  = $clog2(REG_N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_e;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [IDX_W-1:0]  rd;
    logic [IDX_W-1:0]  rs1;
    logic [IDX_W-1:0]  rs2;
    logic              imm_en;
    logic [DATA_W-1:0] imm;
  } cmd_t;

endpackage

// File: rtl/mspc_v_regfile.sv
// 16 x 64 register file: two asynchronous read ports, one synchronous
// write port, asynchronous active-low clear, R0 hardwired to zero.
module mspc_v_regfile
  import mspc_v_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [IDX_W-1:0]  raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [IDX_W-1:0]  raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);

  logic [DATA_W-1:0] mem_q [REG_N];

  // Storage: cleared on reset; writes to R0 are dropped so it stays zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < REG_N; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports: R0 forced to zero independent of storage contents.
  always_comb begin
    rdata_a_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
    rdata_b_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];
  end

endmodule

// File: rtl/mspc_v_exec_seq.sv
// Execute sequencer: accepts one decoded ALU command, reads operands from
// the register file, drives the external combinational ALU, writes the
// result back and presents it on a valid/ready response port.
module mspc_v_exec_seq
  import mspc_v_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [SEL_W-1:0]  cmd_sel,
  input  logic [IDX_W-1:0]  cmd_rd,
  input  logic [IDX_W-1:0]  cmd_rs1,
  input  logic [IDX_W-1:0]  cmd_rs2,
  input  logic              cmd_imm_en,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [DATA_W-1:0] alu_inpa,
  output logic [DATA_W-1:0] alu_inpb,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_numoutp,
  input  logic              alu_booloutp,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_flag,
  output logic [IDX_W-1:0]  rsp_rd,
  output logic              flag_q
);

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic              cmd_acc;
  logic              op_load;
  logic              res_cap;

  logic [DATA_W-1:0] rf_rdata_a;
  logic [DATA_W-1:0] rf_rdata_b;

  logic [DATA_W-1:0] alu_inpa_q, alu_inpa_d;
  logic [DATA_W-1:0] alu_inpb_q, alu_inpb_d;
  logic [SEL_W-1:0]  alu_sel_q,  alu_sel_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_flag_q,   rsp_flag_d;
  logic [IDX_W-1:0]  rsp_rd_q,     rsp_rd_d;
  logic              arch_flag_q,  arch_flag_d;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one command at a time, response held until taken.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid) state_d = READ;
      READ:    state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: handshake outputs come from state only.
  always_comb begin
    cmd_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    op_load   = (state_q == READ);
    res_cap   = (state_q == EXEC);
    cmd_acc   = (state_q == IDLE) && cmd_valid;
  end

  mspc_v_regfile u_regfile (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .raddr_a_i (cmd_q.rs1),
    .rdata_a_o (rf_rdata_a),
    .raddr_b_i (cmd_q.rs2),
    .rdata_b_o (rf_rdata_b),
    .we_i      (res_cap),
    .waddr_i   (cmd_q.rd),
    .wdata_i   (alu_numoutp)
  );

  // Datapath next values: latch on accept, load operands in READ,
  // capture ALU outputs in EXEC; everything else holds.
  always_comb begin
    cmd_d        = cmd_q;
    alu_inpa_d   = alu_inpa_q;
    alu_inpb_d   = alu_inpb_q;
    alu_sel_d    = alu_sel_q;
    rsp_result_d = rsp_result_q;
    rsp_flag_d   = rsp_flag_q;
    rsp_rd_d     = rsp_rd_q;
    arch_flag_d  = arch_flag_q;
    if (cmd_acc) begin
      cmd_d.sel    = cmd_sel;
      cmd_d.rd     = cmd_rd;
      cmd_d.rs1    = cmd_rs1;
      cmd_d.rs2    = cmd_rs2;
      cmd_d.imm_en = cmd_imm_en;
      cmd_d.imm    = cmd_imm;
    end
    if (op_load) begin
      alu_inpa_d = rf_rdata_a;
      alu_inpb_d = cmd_q.imm_en ? cmd_q.imm : rf_rdata_b;
      alu_sel_d  = cmd_q.sel;
    end
    if (res_cap) begin
      rsp_result_d = alu_numoutp;
      rsp_flag_d   = alu_booloutp;
      rsp_rd_d     = cmd_q.rd;
      arch_flag_d  = alu_booloutp;
    end
  end

  // Datapath registers, all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q        <= '0;
      alu_inpa_q   <= '0;
      alu_inpb_q   <= '0;
      alu_sel_q    <= '0;
      rsp_result_q <= '0;
      rsp_flag_q   <= 1'b0;
      rsp_rd_q     <= '0;
      arch_flag_q  <= 1'b0;
    end else begin
      cmd_q        <= cmd_d;
      alu_inpa_q   <= alu_inpa_d;
      alu_inpb_q   <= alu_inpb_d;
      alu_sel_q    <= alu_sel_d;
      rsp_result_q <= rsp_result_d;
      rsp_flag_q   <= rsp_flag_d;
      rsp_rd_q     <= rsp_rd_d;
      arch_flag_q  <= arch_flag_d;
    end
  end

  // Output wiring.
  always_comb begin
    alu_inpa   = alu_inpa_q;
    alu_inpb   = alu_inpb_q;
    alu_sel    = alu_sel_q;
    rsp_result = rsp_result_q;
    rsp_flag   = rsp_flag_q;
    rsp_rd     = rsp_rd_q;
    flag_q     = arch_flag_q;
  end

endmodule

// File: tb/tb_mspc_v_exec_seq.sv
// Self-checking bench for mspc_v_exec_seq with a behavioural ALU and a
// register-file model feeding a scoreboard of expected responses.
module tb_mspc_v_exec_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_sel = '0;
  logic [3:0]  cmd_rd = '0;
  logic [3:0]  cmd_rs1 = '0;
  logic [3:0]  cmd_rs2 = '0;
  logic        cmd_imm_en = 1'b0;
  logic [63:0] cmd_imm = '0;
  logic [63:0] alu_inpa;
  logic [63:0] alu_inpb;
  logic [3:0]  alu_sel;
  logic [63:0] alu_numoutp;
  logic        alu_booloutp;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_result;
  logic        rsp_flag;
  logic [3:0]  rsp_rd;
  logic        flag_q;

  typedef struct {
    logic [63:0] num;
    logic        flag;
    logic [3:0]  rd;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] rf_m [16];
  logic        flag_m;
  int          checks = 0;
  int          errors = 0;

  mspc_v_exec_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_sel      (cmd_sel),
    .cmd_rd       (cmd_rd),
    .cmd_rs1      (cmd_rs1),
    .cmd_rs2      (cmd_rs2),
    .cmd_imm_en   (cmd_imm_en),
    .cmd_imm      (cmd_imm),
    .alu_inpa     (alu_inpa),
    .alu_inpb     (alu_inpb),
    .alu_sel      (alu_sel),
    .alu_numoutp  (alu_numoutp),
    .alu_booloutp (alu_booloutp),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_flag     (rsp_flag),
    .rsp_rd       (rsp_rd),
    .flag_q       (flag_q)
  );

  always #5 clk = ~clk;

  // Bench ALU: 0 = ADD with carry out, 1 = equality compare, others XOR.
  function automatic logic [64:0] alu_f(input logic [3:0] s, input logic [63:0] a,
                                        input logic [63:0] b);
    logic [64:0] r;
    case (s)
      4'd0:    r = {1'b0, a} + {1'b0, b};
      4'd1:    r = {(a == b), 64'd0};
      default: r = {a[0], a ^ b};
    endcase
    return r;
  endfunction

  always_comb {alu_booloutp, alu_numoutp} = alu_f(alu_sel, alu_inpa, alu_inpb);

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    for (int i = 0; i < 16; i++) rf_m[i] = '0;
    flag_m = 1'b0;
    sb_q.delete();
  endtask

  // Offer a command once cmd_ready is seen, predict its response, and
  // scramble the command inputs after the accept edge.
  task automatic issue(input logic [3:0] sel, input logic [3:0] rd, input logic [3:0] rs1,
                       input logic [3:0] rs2, input logic imm_en, input logic [63:0] imm);
    logic [63:0] a, b;
    logic [64:0] r;
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout cmd_ready=%0b required 1", cmd_ready);
      return;
    end
    cmd_sel = sel; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    cmd_imm_en = imm_en; cmd_imm = imm; cmd_valid = 1'b1;
    a = (rs1 == 4'd0) ? 64'd0 : rf_m[rs1];
    b = imm_en ? imm : ((rs2 == 4'd0) ? 64'd0 : rf_m[rs2]);
    r = alu_f(sel, a, b);
    sb_q.push_back('{num: r[63:0], flag: r[64], rd: rd});
    if (rd != 4'd0) rf_m[rd] = r[63:0];
    flag_m = r[64];
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_sel = 4'($urandom); cmd_rd = 4'($urandom); cmd_rs1 = 4'($urandom);
    cmd_rs2 = 4'($urandom); cmd_imm_en = 1'($urandom); cmd_imm = {$urandom(), $urandom()};
  endtask

  // Wait (bounded) for rsp_valid and pop the matching expectation.
  task automatic wait_rsp(output logic ok, output exp_t e);
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    ok = rsp_valid;
    if (sb_q.size() == 0) begin
      ok = 1'b0;
      e = '{num: '0, flag: 1'b0, rd: '0};
    end else begin
      e = sb_q.pop_front();
    end
  endtask

  task automatic test_reset();
    logic ok; exp_t e;
    rst_n = 1'b0; rsp_ready = 1'b0; cmd_valid = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({alu_inpa, alu_inpb, alu_sel, rsp_valid, rsp_result, rsp_flag, rsp_rd, flag_q} !== '0) begin
      errors++;
      $display("FAIL reset_outputs inpa=%h inpb=%h sel=%h rv=%b res=%h rf=%b rd=%h fq=%b required all 0",
               alu_inpa, alu_inpb, alu_sel, rsp_valid, rsp_result, rsp_flag, rsp_rd, flag_q);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cmd_ready got %b required 1", cmd_ready);
    end
    rsp_ready = 1'b1;
    issue(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 64'd0);
    wait_rsp(ok, e);
    checks++;
    if (!ok || rsp_result !== e.num || rsp_flag !== e.flag || rsp_rd !== e.rd) begin
      errors++; $display("FAIL reset_r0_read got ok=%b res=%h flag=%b rd=%h required res=%h flag=%b rd=%h",
                         ok, rsp_result, rsp_flag, rsp_rd, e.num, e.flag, e.rd);
    end
    @(posedge clk); #1;
    issue(4'd0, 4'd7, 4'd5, 4'd9, 1'b0, 64'd0);
    wait_rsp(ok, e);
    checks++;
    if (!ok || rsp_result !== e.num || rsp_rd !== e.rd) begin
      errors++; $display("FAIL reset_rf_clear got res=%h rd=%h required res=%h rd=%h",
                         rsp_result, rsp_rd, e.num, e.rd);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_imm_add();
    logic ok; exp_t e;
    rsp_ready = 1'b1;
    issue(4'd0, 4'd1, 4'd0, 4'd0, 1'b1, 64'h5);
    @(posedge clk); #1;
    checks++;
    if (alu_inpa !== 64'd0 || alu_inpb !== 64'd5 || alu_sel !== 4'd0) begin
      errors++; $display("FAIL imm_operands got a=%h b=%h sel=%h required a=0 b=5 sel=0",
                         alu_inpa, alu_inpb, alu_sel);
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL imm_early_valid got %b required 0", rsp_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL imm_latency got rv=%b cr=%b required rv=1 cr=0", rsp_valid, cmd_ready);
    end
    wait_rsp(ok, e);
    checks++;
    if (!ok || rsp_result !== e.num || rsp_rd !== e.rd || rsp_result !== 64'd5) begin
      errors++; $display("FAIL imm_result got res=%h rd=%h required res=%h rd=%h",
                         rsp_result, rsp_rd, e.num, e.rd);
    end
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL imm_next_ready got cr=%b rv=%b required cr=1 rv=0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic ok; exp_t e;
    rsp_ready = 1'b1;
    issue(4'd0, 4'd2, 4'd1, 4'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB);
    wait_rsp(ok, e);
    checks++;
    if (!ok || rsp_result !== e.num || rsp_flag !== e.flag || rsp_rd !== e.rd) begin
      errors++; $display("FAIL carry_result got res=%h flag=%b rd=%h required res=%h flag=%b rd=%h",
                         rsp_result, rsp_flag, rsp_rd, e.num, e.flag, e.rd);
    end
    checks++;
    if (flag_q !== flag_m) begin
      errors++; $display("FAIL carry_flag_q got %b required %b", flag_q, flag_m);
    end
    @(posedge clk); #1;
    issue(4'd1, 4'd4, 4'd2, 4'd0, 1'b0, 64'd0);
    wait_rsp(ok, e);
    checks++;
    if (!ok || rsp_result !== e.num || rsp_flag !== e.flag || rsp_rd !== e.rd) begin
      errors++; $display("FAIL compare_r2_r0 got res=%h flag=%b rd=%h required res=%h flag=%b rd=%h",
                         rsp_result, rsp_flag, rsp_rd, e.num, e.flag, e.rd);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic ok; exp_t e;
    rsp_ready = 1'b0;
    issue(4'd0, 4'd3, 4'd1, 4'd0, 1'b1, 64'd10);
    wait_rsp(ok, e);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL bp_rsp_timeout rv=%b required 1", rsp_valid);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== e.num || rsp_flag !== e.flag ||
          rsp_rd !== e.rd || cmd_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold cycle %0d got rv=%b res=%h rd=%h cr=%b required rv=1 res=%h rd=%h cr=0",
                           i, rsp_valid, rsp_result, rsp_rd, cmd_ready, e.num, e.rd);
      end
      if (i == 1) begin
        cmd_valid = 1'b1; cmd_rd = 4'd9; cmd_sel = 4'd0; cmd_imm_en = 1'b1; cmd_imm = 64'd99;
      end
      if (i == 2) cmd_valid = 1'b0;
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL bp_before_release got rv=%b required 1", rsp_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got rv=%b cr=%b required rv=0 cr=1", rsp_valid, cmd_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        errors++; $display("FAIL bp_pulse_ignored cycle %0d got rv=%b cr=%b required rv=0 cr=1",
                           i, rsp_valid, cmd_ready);
      end
    end
  endtask

  task automatic test_r0_write();
    logic ok; exp_t e;
    rsp_ready = 1'b1;
    issue(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 64'd7);
    wait_rsp(ok, e);
    checks++;
    if (!ok || rsp_result !== e.num || rsp_rd !== e.rd) begin
      errors++; $display("FAIL r0_write_result got res=%h rd=%h required res=%h rd=%h",
                         rsp_result, rsp_rd, e.num, e.rd);
    end
    @(posedge clk); #1;
    issue(4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 64'd0);
    wait_rsp(ok, e);
    checks++;
    if (!ok || rsp_result !== e.num) begin
      errors++; $display("FAIL r0_readback got res=%h required %h", rsp_result, e.num);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sel_passthrough();
    logic ok; exp_t e;
    rsp_ready = 1'b1;
    for (int s = 0; s < 16; s++) begin
      issue(4'(s), 4'd6, 4'd1, 4'd3, 1'b0, 64'd0);
      @(posedge clk); #1;
      checks++;
      if (alu_sel !== 4'(s) || alu_inpa !== rf_m[1] || alu_inpb !== rf_m[3]) begin
        errors++; $display("FAIL sel_pass sel=%0d got sel=%h a=%h b=%h required sel=%h a=%h b=%h",
                           s, alu_sel, alu_inpa, alu_inpb, 4'(s), rf_m[1], rf_m[3]);
      end
      wait_rsp(ok, e);
      checks++;
      if (!ok || rsp_result !== e.num || rsp_flag !== e.flag || rsp_rd !== e.rd) begin
        errors++; $display("FAIL sel_result sel=%0d got res=%h flag=%b required res=%h flag=%b",
                           s, rsp_result, rsp_flag, e.num, e.flag);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic ok; exp_t e;
    rsp_ready = 1'b1;
    issue(4'd0, 4'd3, 4'd0, 4'd0, 1'b1, 64'd9);
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_assert got rv=%b cr=%b required rv=0 cr=1", rsp_valid, cmd_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        errors++; $display("FAIL midrst_no_rsp cycle %0d got rv=%b cr=%b required rv=0 cr=1",
                           i, rsp_valid, cmd_ready);
      end
    end
    issue(4'd0, 4'd6, 4'd3, 4'd0, 1'b0, 64'd0);
    wait_rsp(ok, e);
    checks++;
    if (!ok || rsp_result !== e.num || rsp_rd !== e.rd) begin
      errors++; $display("FAIL midrst_r3_clear got res=%h rd=%h required res=%h rd=%h",
                         rsp_result, rsp_rd, e.num, e.rd);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_imm_add();
    test_back_to_back();
    test_backpressure();
    test_r0_write();
    test_sel_passthrough();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
